// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLK_ON,
    WAIT_ACK,
    DONE,
    FAULT,
    DRAIN
  } state_t;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_GAP_CYCLES  = 8;
  localparam int DEF_ACK_TIMEOUT = 64;

  function automatic int tmr_w(input int gap, input int ack);
    int m;
    m = (gap > ack) ? gap : ack;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter shared by the sequencer's timed states.
module rst_seq_timer
  import rst_seq_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= value;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staged per-domain reset release with ack/timeout and controlled re-assert.
// Optional: RSTSEQ_REVERSE_EN re-asserts stages one at a time, highest first.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  release_i,
  input  logic [NUM_STAGES-1:0] stage_ack_i,
  output logic [NUM_STAGES-1:0] rst_o,
  output logic [NUM_STAGES-1:0] clk_en_o,
  output logic [IW-1:0]         stage_idx_o,
  output logic                  done_o,
  output logic                  timeout_o
);

  localparam int TW = tmr_w(GAP_CYCLES, ACK_TIMEOUT);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LD = TW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST   = IW'(NUM_STAGES - 1);

  state_t state, state_nx;
  logic [NUM_STAGES-1:0] rst_nx, en_nx;
  logic [IW-1:0] idx_nx;
  logic done_nx, tmo_nx;
  logic load, zero;
  logic [TW-1:0] load_val;

  rst_seq_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .value (load_val),
    .zero  (zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rst_o       <= '1;
      clk_en_o    <= '0;
      stage_idx_o <= '0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state       <= state_nx;
      rst_o       <= rst_nx;
      clk_en_o    <= en_nx;
      stage_idx_o <= idx_nx;
      done_o      <= done_nx;
      timeout_o   <= tmo_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rst_nx   = rst_o;
    en_nx    = clk_en_o;
    idx_nx   = stage_idx_o;
    done_nx  = done_o;
    tmo_nx   = timeout_o;
    load     = 1'b0;
    load_val = GAP_LD;

    if (state != IDLE && state != DRAIN && !release_i) begin
      // Dropping release wins over any ack or timeout this cycle.
      state_nx = DRAIN;
      done_nx  = 1'b0;
      tmo_nx   = 1'b0;
      load     = 1'b1;
`ifdef RSTSEQ_REVERSE_EN
      rst_nx[stage_idx_o] = 1'b1;
`else
      rst_nx = '1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (release_i) begin
            state_nx = CLK_ON;
            en_nx[0] = 1'b1;
            load     = 1'b1;
          end
        end
        CLK_ON: begin
          if (zero) begin
            state_nx            = WAIT_ACK;
            rst_nx[stage_idx_o] = 1'b0;
            load                = 1'b1;
            load_val            = ACK_LD;
          end
        end
        WAIT_ACK: begin
          if (stage_ack_i[stage_idx_o]) begin
            if (stage_idx_o == LAST) begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end else begin
              state_nx      = CLK_ON;
              idx_nx        = stage_idx_o + 1'b1;
              en_nx[idx_nx] = 1'b1;
              load          = 1'b1;
            end
          end else if (zero) begin
            state_nx = FAULT;
            tmo_nx   = 1'b1;
          end
        end
        DRAIN: begin
          if (zero) begin
`ifdef RSTSEQ_REVERSE_EN
            en_nx[stage_idx_o] = 1'b0;
            if (stage_idx_o == '0) begin
              state_nx = IDLE;
            end else begin
              idx_nx         = stage_idx_o - 1'b1;
              rst_nx[idx_nx] = 1'b1;
              load           = 1'b1;
            end
`else
            en_nx    = '0;
            idx_nx   = '0;
            state_nx = IDLE;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed checks of the staged reset sequencer at default parameters.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       release_i;
  logic [3:0] stage_ack_i;
  logic [3:0] rst_o;
  logic [3:0] clk_en_o;
  logic [1:0] stage_idx_o;
  logic       done_o;
  logic       timeout_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic seen;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .release_i   (release_i),
    .stage_ack_i (stage_ack_i),
    .rst_o       (rst_o),
    .clk_en_o    (clk_en_o),
    .stage_idx_o (stage_idx_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Reset the block, then raise release with cycle 0 as the current cycle.
  task automatic start(input logic [3:0] ack);
    reset       = 1'b1;
    release_i   = 1'b0;
    stage_ack_i = ack;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    release_i = 1'b1;
    cyc       = 0;
  endtask

  initial begin
    reset       = 1'b1;
    release_i   = 1'b0;
    stage_ack_i = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_rst", rst_o, 4'hF);
    chk("rst_en", clk_en_o, 4'h0);
    chk("rst_idx", stage_idx_o, 2'd0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_tmo", timeout_o, 1'b0);

    // Normal sequence with acks tied high.
    start(4'hF);
    go(1);
    chk("n_en0", clk_en_o, 4'b0001);
    chk("n_rst_c1", rst_o, 4'hF);
    go(8);
    chk("n_rst_c8", rst_o, 4'hF);
    go(9);
    chk("n_rst0", rst_o, 4'b1110);
    go(10);
    chk("n_en1", clk_en_o, 4'b0011);
    chk("n_idx1", stage_idx_o, 2'd1);
    go(36);
    chk("n_rst3", rst_o, 4'b0000);
    chk("n_done36", done_o, 1'b0);
    go(37);
    chk("n_done", done_o, 1'b1);
    chk("n_en_all", clk_en_o, 4'hF);
    release_i = 1'b0;
    go(38);
    chk("d_done", done_o, 1'b0);
    chk("d_en", clk_en_o, 4'hF);
`ifdef RSTSEQ_REVERSE_EN
    chk("r_rst38", rst_o, 4'b1000);
    go(46);
    chk("r_rst46", rst_o, 4'b1100);
    chk("r_en46", clk_en_o, 4'b0111);
    go(54);
    chk("r_rst54", rst_o, 4'b1110);
    chk("r_en54", clk_en_o, 4'b0011);
    go(62);
    chk("r_rst62", rst_o, 4'hF);
    chk("r_en62", clk_en_o, 4'b0001);
    go(70);
    chk("r_en70", clk_en_o, 4'h0);
    chk("r_idx70", stage_idx_o, 2'd0);
`else
    chk("d_rst", rst_o, 4'hF);
    go(45);
    chk("d_en45", clk_en_o, 4'hF);
    go(46);
    chk("d_en46", clk_en_o, 4'h0);
    chk("d_idx46", stage_idx_o, 2'd0);
`endif

    // Stage 1 never acks: timeout after 64 WAIT_ACK cycles.
    start(4'b1101);
    go(18);
    chk("t_rst1", rst_o, 4'b1100);
    go(81);
    chk("t_tmo81", timeout_o, 1'b0);
    go(82);
    chk("t_tmo82", timeout_o, 1'b1);
    chk("t_rst82", rst_o, 4'b1100);
    chk("t_en82", clk_en_o, 4'b0011);
    go(95);
    chk("t_hold", {timeout_o, rst_o, clk_en_o}, {1'b1, 4'b1100, 4'b0011});

    // Ack arrives in the final WAIT_ACK cycle, same cycle the timer hits 0.
    start(4'b0000);
    go(72);
    stage_ack_i = 4'b0001;
    go(73);
    stage_ack_i = 4'b0000;
    chk("a_tmo", timeout_o, 1'b0);
    chk("a_en", clk_en_o, 4'b0011);
    chk("a_idx", stage_idx_o, 2'd1);
    chk("a_rst", rst_o, 4'b1110);

    // Release drops in stage 2 WAIT_ACK together with its ack.
    start(4'b0011);
    go(27);
    chk("w_rst2", rst_o, 4'b1000);
    stage_ack_i = 4'hF;
    release_i   = 1'b0;
    go(28);
    chk("w_rst", rst_o, 4'hF);
    chk("w_en", clk_en_o, 4'b0111);
    seen = done_o;
    while (cyc < 40) begin
      go(cyc + 1);
      seen = seen | done_o;
    end
    chk("w_nodone", seen, 1'b0);
`ifndef RSTSEQ_REVERSE_EN
    chk("w_en_off", clk_en_o, 4'h0);
`endif

    // Block reset in the middle of CLK_ON.
    start(4'hF);
    go(4);
    chk("m_en", clk_en_o, 4'b0001);
    reset = 1'b1;
    go(5);
    chk("m_all", {rst_o, clk_en_o, stage_idx_o, done_o, timeout_o},
        {4'hF, 4'h0, 2'd0, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
